oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma_ctrl.sv | 90 +++++++++
 tb/tb_oam_dma_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus constants and OAM DMA state encoding.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: halts the CPU and copies one 256-byte page to $2004,
// aligning the first read to an even cycle.
import nes_pkg::*;

module oam_dma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  dma_state_t  r_state;
  dma_state_t  w_next;
  logic        r_odd;
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  r_data;
  logic        w_start;
  logic        w_last;

  assign w_start = (r_state == S_IDLE) && cpu_we &&
                   (cpu_addr == OAMDMA_ADDR);
  assign w_last  = (r_idx == 8'hFF);

  always_comb begin
    w_next     = r_state;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;
    bus_addr   = cpu_addr;
    bus_dout   = cpu_dout;
    bus_we     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        bus_we     = cpu_we;
        if (w_start) w_next = S_HALT;
      end
      S_HALT: begin
        w_next = r_odd ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        w_next = S_READ;
      end
      S_READ: begin
        bus_addr = {r_page, r_idx};
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        bus_addr = OAMDATA_ADDR;
        bus_dout = r_data;
        bus_we   = 1'b1;
        w_next   = w_last ? S_IDLE : S_READ;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_odd   <= 1'b0;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_next;
      r_odd   <= ~r_odd;
      if (w_start) begin
        r_page <= cpu_dout;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ)
        r_data <= bus_din;
      // idx is 8 bits so the source never carries past the page
      if (r_state == S_WRITE && !w_last)
        r_idx <= r_idx + 8'h01;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: transfer timing, data path,
// retrigger immunity, abort by reset and back-to-back transfers.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        dma_active;

  int nerr = 0;
  int nchk = 0;
  logic t_odd = 1'b0;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we),
    .bus_din(bus_din), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // memory model: byte at address a holds a[7:0] ^ A5
  assign bus_din = bus_addr[7:0] ^ 8'hA5;

  // parity model
  always @(posedge clk) t_odd <= rst ? 1'b0 : ~t_odd;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, ".rdy"}, cpu_rdy, 1);
    chk({tag, ".act"}, dma_active, 0);
    chk({tag, ".addr"}, bus_addr, cpu_addr);
    chk({tag, ".dout"}, bus_dout, cpu_dout);
    chk({tag, ".we"}, bus_we, cpu_we);
    tick();
  endtask

  // Starts at posedge+1 in IDLE; returns at posedge+1 after last WRITE.
  task automatic xfer(input string tag, input logic [7:0] pg,
                      input bit inj);
    bit align;
    int low;
    int bad;
    logic [31:0] fo, fe;
    align = t_odd;
    low = 0;
    bad = 0;
    fo = 0;
    fe = 0;
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_we   = 1'b1;
    @(negedge clk);
    chk({tag, ".trig_rdy"}, cpu_rdy, 1);
    chk({tag, ".trig_we"}, {bus_we, bus_addr, bus_dout},
        {1'b1, 16'h4014, pg});
    tick();
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    cpu_dout = 8'h5A;
    for (int h = 0; h < (align ? 2 : 1); h++) begin
      @(negedge clk);
      if ({cpu_rdy, dma_active, bus_we, bus_addr} !==
          {1'b0, 1'b1, 1'b0, 16'h1234}) begin
        if (bad == 0) begin
          fo = {cpu_rdy, dma_active, bus_we, 13'd0, bus_addr};
          fe = {3'b010, 13'd0, 16'h1234};
        end
        bad++;
      end
      if (!cpu_rdy) low++;
      tick();
    end
    for (int i = 0; i < 256; i++) begin
      if (inj && i == 50) begin
        cpu_addr = 16'h4014;
        cpu_dout = 8'h07;
        cpu_we   = 1'b1;
      end
      if (inj && i == 53) begin
        cpu_addr = 16'h1234;
        cpu_we   = 1'b0;
      end
      @(negedge clk);
      if ({cpu_rdy, dma_active, bus_we, bus_addr, t_odd} !==
          {1'b0, 1'b1, 1'b0, pg, i[7:0], 1'b0}) begin
        if (bad == 0) begin
          fo = {i[7:0], t_odd, bus_we, cpu_rdy, 5'd0, bus_addr};
          fe = {i[7:0], 8'h00, pg, i[7:0]};
        end
        bad++;
      end
      if (!cpu_rdy) low++;
      tick();
      @(negedge clk);
      if ({cpu_rdy, dma_active, bus_we, bus_addr, bus_dout} !==
          {1'b0, 1'b1, 1'b1, 16'h2004, i[7:0] ^ 8'hA5}) begin
        if (bad == 0) begin
          fo = {i[7:0], bus_we, cpu_rdy, 6'd0, bus_dout, bus_addr[7:0]};
          fe = {i[7:0], 8'h80, i[7:0] ^ 8'hA5, 8'h04};
        end
        bad++;
      end
      if (!cpu_rdy) low++;
      tick();
    end
    chk({tag, ".beats"}, bad, 0);
    if (bad != 0) chk({tag, ".first_bad"}, fo, fe);
    chk({tag, ".halt_len"}, low, align ? 514 : 513);
  endtask

  initial begin
    rst      = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_we   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state and passthrough
    cpu_addr = 16'hBEEF; cpu_dout = 8'h3C; cpu_we = 1'b0;
    chk_idle("rst0");
    cpu_addr = 16'h4015; cpu_dout = 8'h02; cpu_we = 1'b1;
    chk_idle("pass_we");
    cpu_we = 1'b0;
    chk_idle("no_trig");

    // odd=1 in HALT: trigger when model parity is 0
    if (t_odd) tick();
    xfer("x02_odd", 8'h02, 1'b0);
    cpu_addr = 16'h0300; cpu_we = 1'b0;
    chk_idle("after02");

    // odd=0 in HALT: one ALIGN cycle
    if (!t_odd) tick();
    xfer("x02_even", 8'h02, 1'b0);

    // top page, no wrap, then immediate back-to-back retrigger
    xfer("xFF", 8'hFF, 1'b0);
    xfer("x03_inj", 8'h03, 1'b1);
    cpu_addr = 16'h4014; cpu_dout = 8'h09; cpu_we = 1'b0;
    chk_idle("post_inj");

    // abort mid-transfer with reset
    cpu_addr = 16'h4014; cpu_dout = 8'h06; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int k = 0; k < 100; k++) tick();
    @(negedge clk);
    chk("abort.busy", cpu_rdy, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_addr = 16'h8001; cpu_dout = 8'hE1; cpu_we = 1'b1;
    chk_idle("abort0");
    cpu_we = 1'b0;
    chk_idle("abort1");
    chk_idle("abort2");
    xfer("x04", 8'h04, 1'b0);
    cpu_addr = 16'h2222; cpu_dout = 8'h11; cpu_we = 1'b0;
    chk_idle("final");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
